// File: rtl/wdog_pkg.sv
// Shared constants for the watchdog timer: register map, CTRL bit
// positions and the default unlock key.
package wdog_pkg;

  localparam logic [3:0] WDOG_LOAD     = 4'h0;
  localparam logic [3:0] WDOG_VALUE    = 4'h1;
  localparam logic [3:0] WDOG_CTRL     = 4'h2;
  localparam logic [3:0] WDOG_INTCLR   = 4'h3;
  localparam logic [3:0] WDOG_RIS      = 4'h4;
  localparam logic [3:0] WDOG_MIS      = 4'h5;
  localparam logic [3:0] WDOG_PRESCALE = 4'h6;
  localparam logic [3:0] WDOG_LOCK     = 4'h7;

  localparam int CTRL_INTEN = 0;
  localparam int CTRL_RESEN = 1;

  localparam logic [31:0] DEFAULT_LOCK_KEY = 32'h1ACCE551;

endpackage

// File: rtl/wdog_prescaler.sv
// Prescale counter: produces a one-cycle tick every prescale+1 cycles
// while enabled; held at zero while disabled or cleared.
module wdog_prescaler #(
  parameter int PRE_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic                 clr,
  input  logic [PRE_WIDTH-1:0] prescale,
  output logic                 tick
);

  logic [PRE_WIDTH-1:0] pcnt;

  // The tick must be seen in the same cycle the counter matches, so it
  // is decoded directly from the counter state.
  assign tick = en & (pcnt == prescale);

  // Prescale counter: wraps to zero on a tick, clear or disable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pcnt <= {PRE_WIDTH{1'b0}};
    end else if (clr || !en || tick) begin
      pcnt <= {PRE_WIDTH{1'b0}};
    end else begin
      pcnt <= pcnt + PRE_WIDTH'(1);
    end
  end

endmodule

// File: rtl/wdog_timer.sv
// Watchdog timer: register file, down-counter engine and read mux.
// First timeout raises RIS (WDOGINT when enabled); an unserviced second
// timeout with RESEN set raises the sticky WDOGRES.
module wdog_timer
  import wdog_pkg::*;
#(
  parameter int                   CNT_WIDTH  = 32,
  parameter int                   PRE_WIDTH  = 8,
  parameter logic [31:0]          LOCK_KEY   = DEFAULT_LOCK_KEY,
  parameter logic [CNT_WIDTH-1:0] RESET_LOAD = {CNT_WIDTH{1'b1}}
) (
  input  logic        CLK,
  input  logic        RESETn,
  input  logic [3:0]  ADDR,
  input  logic        WRITE,
  input  logic [31:0] WDATA,
  output logic [31:0] RDATA,
  input  logic        KICK,
  output logic        WDOGINT,
  output logic        WDOGRES
);

  logic [CNT_WIDTH-1:0] load;
  logic [CNT_WIDTH-1:0] count;
  logic [1:0]           ctrl;
  logic [PRE_WIDTH-1:0] prescale;
  logic                 ris;
  logic                 locked;

  logic wr_load, wr_ctrl, wr_intclr, wr_pre, wr_lock;
  logic inten, resen, service, inten_rise, tick, timeout, pre_clr;

  // Write decode; LOCK is the only register that ignores the lock.
  assign wr_load   = WRITE & (ADDR == WDOG_LOAD)     & ~locked;
  assign wr_ctrl   = WRITE & (ADDR == WDOG_CTRL)     & ~locked;
  assign wr_intclr = WRITE & (ADDR == WDOG_INTCLR)   & ~locked;
  assign wr_pre    = WRITE & (ADDR == WDOG_PRESCALE) & ~locked;
  assign wr_lock   = WRITE & (ADDR == WDOG_LOCK);

  assign inten      = ctrl[CTRL_INTEN];
  assign resen      = ctrl[CTRL_RESEN];
  // KICK behaves exactly like an INTCLR write but bypasses the lock.
  assign service    = KICK | wr_intclr;
  assign inten_rise = wr_ctrl & WDATA[CTRL_INTEN] & ~inten;
  assign pre_clr    = wr_load | service | inten_rise;
  // A service or LOAD write in the same cycle swallows the timeout.
  assign timeout    = tick & (count == {CNT_WIDTH{1'b0}}) & ~service & ~wr_load;

  assign WDOGINT = ris & inten;

  wdog_prescaler #(
    .PRE_WIDTH (PRE_WIDTH)
  ) u_prescaler (
    .clk      (CLK),
    .rst_n    (RESETn),
    .en       (inten),
    .clr      (pre_clr),
    .prescale (prescale),
    .tick     (tick)
  );

  // Programmable registers: LOAD, CTRL, PRESCALE and the lock flag.
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      load     <= RESET_LOAD;
      ctrl     <= 2'b00;
      prescale <= {PRE_WIDTH{1'b0}};
      locked   <= 1'b0;
    end else begin
      if (wr_load) load     <= WDATA[CNT_WIDTH-1:0];
      if (wr_ctrl) ctrl     <= WDATA[1:0];
      if (wr_pre)  prescale <= WDATA[PRE_WIDTH-1:0];
      if (wr_lock) locked   <= (WDATA != LOCK_KEY);
    end
  end

  // Down-counter: LOAD write wins, then service/enable reload, then tick.
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      count <= RESET_LOAD;
    end else if (wr_load) begin
      count <= WDATA[CNT_WIDTH-1:0];
    end else if (service || inten_rise) begin
      count <= load;
    end else if (tick) begin
      count <= (count == {CNT_WIDTH{1'b0}}) ? load : (count - CNT_WIDTH'(1));
    end
  end

  // Raw interrupt and sticky reset request, both set on the timeout edge.
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      ris     <= 1'b0;
      WDOGRES <= 1'b0;
    end else begin
      if (service) begin
        ris <= 1'b0;
      end else if (timeout) begin
        ris <= 1'b1;
      end
      if (timeout && ris && resen) begin
        WDOGRES <= 1'b1;
      end
    end
  end

  // Read mux, zero-extended to the bus width.
  always_comb begin
    RDATA = 32'h0000_0000;
    case (ADDR)
      WDOG_LOAD:     RDATA = 32'(load);
      WDOG_VALUE:    RDATA = 32'(count);
      WDOG_CTRL:     RDATA = {30'd0, ctrl};
      WDOG_INTCLR:   RDATA = 32'h0000_0000;
      WDOG_RIS:      RDATA = {31'd0, ris};
      WDOG_MIS:      RDATA = {31'd0, WDOGINT};
      WDOG_PRESCALE: RDATA = 32'(prescale);
      WDOG_LOCK:     RDATA = {31'd0, locked};
      default:       RDATA = 32'h0000_0000;
    endcase
  end

endmodule

// File: tb/tb_wdog_timer.sv
// Self-checking bench for wdog_timer: a register access vector table
// followed by hand-written timeout, service-race, lock and gating sequences.
module tb_wdog_timer;
  import wdog_pkg::*;

  logic        CLK;
  logic        RESETn;
  logic [3:0]  ADDR;
  logic        WRITE;
  logic [31:0] WDATA;
  logic [31:0] RDATA;
  logic        KICK;
  logic        WDOGINT;
  logic        WDOGRES;

  localparam int K_RDATA = 0;
  localparam int K_INT   = 1;
  localparam int K_RES   = 2;

  typedef struct {
    int          kind;
    logic [31:0] exp;
  } exp_t;

  typedef struct {
    logic        wr;
    logic [3:0]  addr;
    logic [31:0] wdata;
    logic [3:0]  raddr;
    logic [31:0] exp;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[14];
  int   total = 0;
  int   bad   = 0;

  wdog_timer dut (
    .CLK     (CLK),
    .RESETn  (RESETn),
    .ADDR    (ADDR),
    .WRITE   (WRITE),
    .WDATA   (WDATA),
    .RDATA   (RDATA),
    .KICK    (KICK),
    .WDOGINT (WDOGINT),
    .WDOGRES (WDOGRES)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Hard stop so the run can never hang.
  initial begin
    #2000000;
    $display("FAIL timeout: simulation exceeded its time budget");
    $fatal(1, "time budget exceeded");
  end

  // Advance n clock edges, ending 1 ns after the last rising edge.
  task automatic step(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  // One bus write, captured on the next rising edge.
  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    ADDR  = a;
    WDATA = d;
    WRITE = 1'b1;
    @(posedge CLK);
    #1;
    WRITE = 1'b0;
  endtask

  // Push an expectation, let the DUT settle, pop and compare.
  task automatic peek(input int kind, input logic [3:0] a, input logic [31:0] exp,
                      input string name);
    exp_t        e;
    logic [31:0] act;
    ADDR   = a;
    e.kind = kind;
    e.exp  = exp;
    sb.push_back(e);
    #1;
    e = sb.pop_front();
    case (e.kind)
      K_RDATA: act = RDATA;
      K_INT:   act = {31'd0, WDOGINT};
      default: act = {31'd0, WDOGRES};
    endcase
    total++;
    if (act !== e.exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, e.exp);
    end
  endtask

  task automatic do_reset();
    RESETn = 1'b0;
    @(posedge CLK);
    #1;
    RESETn = 1'b1;
  endtask

  initial begin
    RESETn = 1'b0;
    ADDR   = 4'h0;
    WRITE  = 1'b0;
    WDATA  = 32'h0;
    KICK   = 1'b0;
    step(2);
    RESETn = 1'b1;

    // Register access table (counting disabled throughout).
    vecs[0]  = '{1'b1, WDOG_LOAD,     32'h0000_1234, WDOG_LOAD,     32'h0000_1234};
    vecs[1]  = '{1'b0, WDOG_LOAD,     32'h0,         WDOG_VALUE,    32'h0000_1234};
    vecs[2]  = '{1'b1, WDOG_PRESCALE, 32'h0000_01FF, WDOG_PRESCALE, 32'h0000_00FF};
    vecs[3]  = '{1'b1, WDOG_CTRL,     32'hFFFF_FFFE, WDOG_CTRL,     32'h0000_0002};
    vecs[4]  = '{1'b1, WDOG_CTRL,     32'h0,         WDOG_CTRL,     32'h0000_0000};
    vecs[5]  = '{1'b1, WDOG_INTCLR,   32'h0000_FFFF, WDOG_INTCLR,   32'h0000_0000};
    vecs[6]  = '{1'b0, WDOG_LOAD,     32'h0,         WDOG_RIS,      32'h0000_0000};
    vecs[7]  = '{1'b0, WDOG_LOAD,     32'h0,         WDOG_MIS,      32'h0000_0000};
    vecs[8]  = '{1'b1, 4'h9,          32'h0000_DEAD, 4'h9,          32'h0000_0000};
    vecs[9]  = '{1'b1, WDOG_LOCK,     32'h0000_0005, WDOG_LOCK,     32'h0000_0001};
    vecs[10] = '{1'b1, WDOG_PRESCALE, 32'h0000_0003, WDOG_PRESCALE, 32'h0000_00FF};
    vecs[11] = '{1'b1, WDOG_LOCK,     32'h1ACC_E551, WDOG_LOCK,     32'h0000_0000};
    vecs[12] = '{1'b1, WDOG_PRESCALE, 32'h0000_0003, WDOG_PRESCALE, 32'h0000_0003};
    vecs[13] = '{1'b0, WDOG_LOAD,     32'h0,         WDOG_VALUE,    32'h0000_1234};

    for (int i = 0; i < 14; i++) begin
      if (vecs[i].wr) wr(vecs[i].addr, vecs[i].wdata);
      else            step(1);
      peek(K_RDATA, vecs[i].raddr, vecs[i].exp, $sformatf("vec%0d", i));
    end

    // Reset asserted in the middle of a count, with lock set.
    do_reset();
    wr(WDOG_LOAD, 32'd20);
    wr(WDOG_CTRL, 32'd3);
    wr(WDOG_LOCK, 32'd0);
    step(5);
    RESETn = 1'b0;
    peek(K_RDATA, WDOG_LOAD,  32'hFFFF_FFFF, "rst_load");
    peek(K_RDATA, WDOG_VALUE, 32'hFFFF_FFFF, "rst_value");
    peek(K_RDATA, WDOG_CTRL,  32'h0,         "rst_ctrl");
    peek(K_RDATA, WDOG_RIS,   32'h0,         "rst_ris");
    peek(K_RDATA, WDOG_LOCK,  32'h0,         "rst_lock");
    peek(K_INT,   WDOG_LOCK,  32'h0,         "rst_int");
    peek(K_RES,   WDOG_LOCK,  32'h0,         "rst_res");
    step(1);
    RESETn = 1'b1;

    // First timeout with PRESCALE=0: VALUE steps 5..0, then reload + RIS.
    wr(WDOG_LOAD, 32'd5);
    wr(WDOG_PRESCALE, 32'd0);
    wr(WDOG_CTRL, 32'd1);
    for (int i = 0; i < 6; i++) begin
      peek(K_RDATA, WDOG_VALUE, 32'(5 - i), $sformatf("t2_value%0d", i));
      step(1);
    end
    peek(K_RDATA, WDOG_RIS,   32'd1, "t2_ris");
    peek(K_INT,   WDOG_RIS,   32'd1, "t2_int");
    peek(K_RDATA, WDOG_VALUE, 32'd5, "t2_reload");
    // Second timeout with RESEN=0 does nothing further.
    step(6);
    peek(K_RDATA, WDOG_VALUE, 32'd5, "t2_value_2nd");
    peek(K_RDATA, WDOG_RIS,   32'd1, "t2_ris_2nd");
    peek(K_RES,   WDOG_RIS,   32'd0, "t2_nores");
    wr(WDOG_INTCLR, 32'd0);
    peek(K_RDATA, WDOG_RIS, 32'd0, "t2_intclr_ris");
    peek(K_INT,   WDOG_RIS, 32'd0, "t2_intclr_int");

    // Second timeout with RESEN=1: RIS at 12 cycles, WDOGRES at 24, sticky.
    do_reset();
    wr(WDOG_LOAD, 32'd3);
    wr(WDOG_PRESCALE, 32'd2);
    wr(WDOG_CTRL, 32'd3);
    step(11);
    peek(K_RDATA, WDOG_RIS, 32'd0, "t3_ris_early");
    step(1);
    peek(K_RDATA, WDOG_RIS, 32'd1, "t3_ris");
    step(11);
    peek(K_RES, WDOG_RIS, 32'd0, "t3_res_early");
    step(1);
    peek(K_RES, WDOG_RIS, 32'd1, "t3_res");
    step(20);
    wr(WDOG_INTCLR, 32'd0);
    peek(K_RES, WDOG_RIS, 32'd1, "t3_res_sticky");
    RESETn = 1'b0;
    peek(K_RES, WDOG_RIS, 32'd0, "t3_res_cleared");
    step(1);
    RESETn = 1'b1;

    // KICK on the exact cycle of the second timeout wins.
    wr(WDOG_LOAD, 32'd3);
    wr(WDOG_PRESCALE, 32'd2);
    wr(WDOG_CTRL, 32'd3);
    step(12);
    peek(K_RDATA, WDOG_RIS, 32'd1, "t4_ris_first");
    step(11);
    KICK = 1'b1;
    @(posedge CLK);
    #1;
    KICK = 1'b0;
    peek(K_RES,   WDOG_RIS,   32'd0, "t4_res");
    peek(K_RDATA, WDOG_RIS,   32'd0, "t4_ris");
    peek(K_RDATA, WDOG_VALUE, 32'd3, "t4_value");
    step(11);
    peek(K_RDATA, WDOG_RIS, 32'd0, "t4_ris_restart_early");
    step(1);
    peek(K_RDATA, WDOG_RIS, 32'd1, "t4_ris_restart");

    // Lock blocks LOAD writes until the key is written.
    do_reset();
    wr(WDOG_LOCK, 32'd0);
    peek(K_RDATA, WDOG_LOCK, 32'd1, "t5_locked");
    wr(WDOG_LOAD, 32'd7);
    peek(K_RDATA, WDOG_LOAD, 32'hFFFF_FFFF, "t5_load_blocked");
    wr(WDOG_LOCK, 32'h1ACC_E551);
    wr(WDOG_LOAD, 32'd7);
    peek(K_RDATA, WDOG_LOAD, 32'd7, "t5_load");
    peek(K_RDATA, WDOG_LOCK, 32'd0, "t5_unlocked");

    // INTEN gating freezes VALUE; re-enable reloads; LOAD=0 times out at once.
    do_reset();
    wr(WDOG_LOAD, 32'd10);
    wr(WDOG_CTRL, 32'd1);
    step(3);
    peek(K_RDATA, WDOG_VALUE, 32'd7, "t6_value_run");
    wr(WDOG_CTRL, 32'd0);
    peek(K_RDATA, WDOG_VALUE, 32'd6, "t6_value_stop");
    step(5);
    peek(K_RDATA, WDOG_VALUE, 32'd6, "t6_value_frozen");
    wr(WDOG_CTRL, 32'd1);
    peek(K_RDATA, WDOG_VALUE, 32'd10, "t6_value_reload");
    wr(WDOG_LOAD, 32'd0);
    peek(K_RDATA, WDOG_RIS, 32'd0, "t6_ris_before");
    step(1);
    peek(K_RDATA, WDOG_RIS, 32'd1, "t6_ris_load0");
    peek(K_RDATA, WDOG_MIS, 32'd1, "t6_mis_load0");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/wdog_timer.md
Name: wdog_timer

Overview:
Parametrised, register-programmable watchdog timer with the address-decoded register file and count engine in one block. A down-counter with a programmable prescaler raises WDOGINT on the first timeout. If the interrupt is not serviced before the second timeout, it raises WDOGRES. The block sits on the same simple word-addressed bus (ADDR/WRITE/WDATA/RDATA) as the existing watchdog decode and feeds the interrupt and reset controllers.

Parameters:
CNT_WIDTH, 32, width of the LOAD register and the down-counter (8..32).
PRE_WIDTH, 8, width of the PRESCALE register (1..16).
LOCK_KEY, 32'h1ACCE551, value written to LOCK that unlocks register writes.
RESET_LOAD, {CNT_WIDTH{1'b1}}, reset value of LOAD and of the counter.

Ports:
CLK  in  1  system clock; all state on the rising edge.
RESETn  in  1  asynchronous, active-low reset.
ADDR  in  4  word register index.
WRITE  in  1  write strobe; WDATA is captured on a CLK edge while WRITE=1.
WDATA  in  32  write data.
RDATA  out  32  read data; combinational from ADDR, zero-extended.
KICK  in  1  hardware service pulse, one CLK wide.
WDOGINT  out  1  interrupt, equal to RIS & INTEN.
WDOGRES  out  1  watchdog reset request; registered and sticky until RESETn.

Behaviour:
Reset: the asynchronous, active-low RESETn forces LOAD=RESET_LOAD, count=RESET_LOAD, CTRL=0, PRESCALE=0, prescale counter=0, RIS=0, locked=0, WDOGRES=0. WDOGINT therefore reads 0 and RDATA reflects the reset values.

Register map (ADDR):
- 0x0 LOAD (RW, CNT_WIDTH bits): a write also reloads the count and clears the prescale counter.
- 0x1 VALUE (RO): current count.
- 0x2 CTRL (RW): bit0 INTEN (counting and interrupt enable), bit1 RESEN (reset enable).
- 0x3 INTCLR (WO, reads 0): any write clears RIS, reloads the count from LOAD and clears the prescale counter.
- 0x4 RIS (RO): bit0 raw interrupt.
- 0x5 MIS (RO): bit0 = RIS & INTEN.
- 0x6 PRESCALE (RW, PRE_WIDTH bits).
- 0x7 LOCK (RW): a write of LOCK_KEY clears locked; any other write value sets locked. Read returns bit0 = locked.
- 0x8..0xF: read 0, writes ignored.

Lock rules:
- While locked=1, writes to 0x0, 0x2, 0x3 and 0x6 are ignored.
- LOCK itself is always writable.
- KICK is never subject to lock and acts exactly like an INTCLR write.

Write/read timing: written values are visible on RDATA in the cycle after the write edge.

Prescaler and tick:
- While INTEN=1, the prescale counter increments each CLK.
- When it equals PRESCALE, a tick occurs and the prescale counter returns to 0. A tick therefore occurs every PRESCALE+1 cycles.
- While INTEN=0, the prescale counter is held at 0 and the count is frozen.

Count:
- On a tick with count != 0: count decrements by 1.
- On a tick with count == 0: count reloads from LOAD. Then:
  - if RIS=0, RIS is set;
  - if RIS=1 and RESEN=1, WDOGRES is set;
  - if RIS=1 and RESEN=0, nothing further happens (RIS stays 1).
- A 0->1 transition of INTEN (CTRL write) reloads the count from LOAD and clears the prescale counter.

Priority when events coincide in one cycle:
1. An INTCLR write or KICK beats a same-cycle timeout: RIS ends 0, the count equals LOAD and WDOGRES is not set.
2. A LOAD write beats a tick: the count takes the new WDATA value.
3. An INTCLR write and a LOAD write cannot coincide, since there is one address per cycle.

Boundary cases:
- LOAD=0: every tick is a timeout, so the first tick sets RIS and the next tick sets WDOGRES when RESEN=1.
- WDATA bits above CNT_WIDTH or PRE_WIDTH are discarded.

Latency: RIS and WDOGRES are set at the clock edge of the timeout tick. WDOGINT follows RIS with no added delay.

Reset mid-operation: RESETn low at any time immediately returns all state to the reset values, including clearing a sticky WDOGRES.

Decomposition:
- Package wdog_pkg: register address constants (WDOG_LOAD..WDOG_LOCK), CTRL bit positions (CTRL_INTEN=0, CTRL_RESEN=1) and the default LOCK_KEY value.
- Sub-module wdog_prescaler (PRE_WIDTH): inputs en, clr and prescale; output tick. The register file, count engine and read mux stay in wdog_timer.

Test Plan:
1. Reset: assert RESETn=0 mid-count -> RDATA@0x0 and 0x1 = 0xFFFFFFFF; CTRL, RIS and LOCK read 0; WDOGINT=0 and WDOGRES=0 immediately.
2. First timeout: LOAD=5, PRESCALE=0, CTRL=1 -> VALUE steps 5,4,3,2,1,0. On the next cycle RIS=1, WDOGINT=1 and VALUE=5.
3. Second timeout: LOAD=3, PRESCALE=2, CTRL=3, no service -> RIS after 12 cycles, WDOGRES=1 after 24 cycles. WDOGRES stays 1 until RESETn.
4. Service race: raise KICK on the exact cycle of the second timeout (same cycle as the count==0 tick) -> WDOGRES stays 0, RIS=0, VALUE=LOAD.
5. Lock: write LOCK=0 -> LOCK reads 1; then write LOAD=7 -> LOAD unchanged. Write LOCK=0x1ACCE551 then LOAD=7 -> LOAD reads 7 and LOCK reads 0.
6. Gating: clear INTEN mid-count -> VALUE frozen. Set INTEN again -> VALUE reloads to LOAD. Write LOAD=0 with INTEN=1 -> RIS=1 after the first tick.
